// File: rtl/deint_frame_sync_ctrl.sv
// Frame-synchronisation controller for de_interleaver_v2: hunts, verifies and
// flywheels on the frame marker, forwarding only payload words downstream.
module deint_frame_sync_ctrl #(
    parameter int          FRAME_SIZE_IN_WORDS = 70,
    parameter int          NUM_CODEWORDS       = 4,
    parameter logic [31:0] SYNC_WORD           = 32'h1ACFFC1D,
    parameter logic [31:0] SYNC_MASK           = 32'hFFFFFFFF,
    parameter int          VERIFY_CNT          = 2,
    parameter int          MISS_LIMIT          = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        sync_reset_o,
    output logic        locked_o,
    output logic [15:0] lock_loss_cnt_o
);
    localparam int BLOCK_WORDS = FRAME_SIZE_IN_WORDS * NUM_CODEWORDS;
    localparam int SW = $clog2(BLOCK_WORDS + 1);
    localparam int MW = $clog2(VERIFY_CNT + 1);
    localparam int XW = $clog2(MISS_LIMIT + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;

    state_t          state, state_n;
    logic [SW-1:0]   slot_cnt, slot_cnt_n, slot_inc;
    logic [MW-1:0]   match_cnt, match_cnt_n, match_inc;
    logic [XW-1:0]   miss_cnt, miss_cnt_n, miss_inc;
    logic [15:0]     loss_cnt_n;
    logic            sync_n;
    logic            is_match, payload_slot, accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= HUNT;
            slot_cnt        <= '0;
            match_cnt       <= '0;
            miss_cnt        <= '0;
            sync_reset_o    <= 1'b0;
            locked_o        <= 1'b0;
            lock_loss_cnt_o <= '0;
        end else begin
            state           <= state_n;
            slot_cnt        <= slot_cnt_n;
            match_cnt       <= match_cnt_n;
            miss_cnt        <= miss_cnt_n;
            sync_reset_o    <= sync_n;
            locked_o        <= (state_n == LOCK);
            lock_loss_cnt_o <= loss_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        slot_cnt_n   = slot_cnt;
        match_cnt_n  = match_cnt;
        miss_cnt_n   = miss_cnt;
        loss_cnt_n   = lock_loss_cnt_o;
        sync_n       = 1'b0;

        is_match     = ((s_axis_tdata ^ SYNC_WORD) & SYNC_MASK) == '0;
        payload_slot = (state == LOCK) && (slot_cnt != '0);
        // Slot 1 is held off while the sync pulse is out so the de-interleaver
        // never sees its sync and a payload transfer in the same cycle.
        s_axis_tready = payload_slot ? (m_axis_tready && !sync_reset_o) : 1'b1;
        m_axis_tvalid = payload_slot && s_axis_tvalid && !sync_reset_o;
        m_axis_tdata  = s_axis_tdata;
        accept        = s_axis_tvalid && s_axis_tready;

        slot_inc  = (slot_cnt == SW'(BLOCK_WORDS)) ? '0 : slot_cnt + 1'b1;
        match_inc = match_cnt + 1'b1;
        miss_inc  = miss_cnt + 1'b1;

        if (accept) begin
            unique case (state)
                HUNT: begin
                    if (is_match) begin
                        state_n     = VERIFY;
                        slot_cnt_n  = SW'(1);
                        match_cnt_n = '0;
                    end
                end
                VERIFY: begin
                    if (slot_cnt != '0) begin
                        slot_cnt_n = slot_inc;
                    end else if (is_match) begin
                        slot_cnt_n  = SW'(1);
                        match_cnt_n = match_inc;
                        if (match_inc == MW'(VERIFY_CNT)) begin
                            state_n    = LOCK;
                            miss_cnt_n = '0;
                            sync_n     = 1'b1;
                        end
                    end else begin
                        state_n    = HUNT;
                        slot_cnt_n = '0;
                    end
                end
                LOCK: begin
                    if (slot_cnt != '0) begin
                        slot_cnt_n = slot_inc;
                    end else if (is_match) begin
                        slot_cnt_n = SW'(1);
                        miss_cnt_n = '0;
                        sync_n     = 1'b1;
                    end else if (miss_inc == XW'(MISS_LIMIT)) begin
                        state_n    = HUNT;
                        slot_cnt_n = '0;
                        miss_cnt_n = '0;
                        loss_cnt_n = (lock_loss_cnt_o == 16'hFFFF) ? lock_loss_cnt_o
                                                                   : lock_loss_cnt_o + 16'd1;
                    end else begin
                        slot_cnt_n = SW'(1);
                        miss_cnt_n = miss_inc;
                    end
                end
                default: begin
                    state_n    = HUNT;
                    slot_cnt_n = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_deint_frame_sync_ctrl.sv
// Scoreboard bench for deint_frame_sync_ctrl: 3-word codewords, 2 per block.
module tb_deint_frame_sync_ctrl;
    localparam logic [31:0] SYNC = 32'h1ACFFC1D;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        sync_reset_o;
    logic        locked_o;
    logic [15:0] lock_loss_cnt_o;

    typedef struct packed {
        logic        is_sync;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       bp_en  = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    int         bp_idx = 0;

    deint_frame_sync_ctrl #(
        .FRAME_SIZE_IN_WORDS(3),
        .NUM_CODEWORDS(2),
        .SYNC_WORD(SYNC),
        .SYNC_MASK(32'hFFFFFFFF),
        .VERIFY_CNT(2),
        .MISS_LIMIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .sync_reset_o(sync_reset_o),
        .locked_o(locked_o),
        .lock_loss_cnt_o(lock_loss_cnt_o)
    );

    always #5 clk = ~clk;

    // Downstream ready: steady high, or the 1,0,0,1 pattern while bp_en is set.
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            m_axis_tready = bp_pat[3 - bp_idx];
            bp_idx = (bp_idx + 1) % 4;
        end else begin
            m_axis_tready = 1'b1;
            bp_idx = 0;
        end
    end

    // Monitor: every sync pulse and every downstream transfer consumes one entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sync_reset_o && m_axis_tvalid && m_axis_tready) begin
                checks++; errors++;
                $display("FAIL sync_vs_xfer actual=coincident required=separate");
            end
            if (sync_reset_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sync_pulse actual=pulse required=none");
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_sync) begin
                        errors++;
                        $display("FAIL sync_order actual=pulse required=data %0h", e.data);
                    end
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL payload actual=%0h required=none", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_sync || m_axis_tdata !== e.data) begin
                        errors++;
                        $display("FAIL payload actual=%0h required=%s%0h", m_axis_tdata,
                                 e.is_sync ? "sync " : "", e.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_sync();
        exp_t e;
        e.is_sync = 1'b1;
        e.data    = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_data(input logic [31:0] d);
        exp_t e;
        e.is_sync = 1'b0;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] d);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=stalled required=accepted word %0h", d);
        end
    endtask

    task automatic send_frame(input logic [31:0] marker, input logic [31:0] base,
                              input bit exp_sync, input bit exp_fwd);
        if (exp_sync) push_sync();
        if (exp_fwd) for (int i = 1; i <= 6; i++) push_data(base + 32'(i));
        send_word(marker);
        for (int i = 1; i <= 6; i++) send_word(base + 32'(i));
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_locked", 32'(locked_o), 32'd0);
        chk("rst_loss_cnt", 32'(lock_loss_cnt_o), 32'd0);
        chk("rst_sync", 32'(sync_reset_o), 32'd0);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(posedge clk); #1;

        // False marker: marker, block, then a non-marker at slot 0.
        send_word(SYNC);
        for (int i = 1; i <= 6; i++) send_word(32'(i));
        send_word(32'h5);
        send_word(32'h7);
        send_word(32'h8);
        chk("false_marker_locked", 32'(locked_o), 32'd0);

        // Acquisition: third marker confirms lock.
        send_frame(SYNC, 32'h0, 1'b0, 1'b0);
        send_frame(SYNC, 32'h0, 1'b0, 1'b0);
        chk("acq_not_yet_locked", 32'(locked_o), 32'd0);
        send_frame(SYNC, 32'h0, 1'b1, 1'b1);
        chk("acq_locked", 32'(locked_o), 32'd1);

        // Flywheel through one corrupt marker, then a good one.
        send_frame(32'h0, 32'h10, 1'b0, 1'b1);
        chk("flywheel_locked", 32'(locked_o), 32'd1);
        send_frame(SYNC, 32'h20, 1'b1, 1'b1);

        // Backpressure during payload.
        bp_en = 1'b1;
        send_frame(SYNC, 32'h30, 1'b1, 1'b1);
        send_frame(SYNC, 32'h40, 1'b1, 1'b1);
        bp_en = 1'b0;
        chk("bp_locked", 32'(locked_o), 32'd1);

        // Loss of lock: three consecutive corrupt markers.
        send_frame(32'h0, 32'h50, 1'b0, 1'b1);
        send_frame(32'h0, 32'h60, 1'b0, 1'b1);
        chk("miss2_locked", 32'(locked_o), 32'd1);
        send_frame(32'h0, 32'h70, 1'b0, 1'b0);
        chk("loss_locked", 32'(locked_o), 32'd0);
        chk("loss_cnt", 32'(lock_loss_cnt_o), 32'd1);

        // Reacquire, then reset in the middle of a frame.
        send_frame(SYNC, 32'h80, 1'b0, 1'b0);
        send_frame(SYNC, 32'h80, 1'b0, 1'b0);
        send_frame(SYNC, 32'h80, 1'b1, 1'b1);
        chk("reacq_locked", 32'(locked_o), 32'd1);
        push_sync();
        for (int i = 1; i <= 3; i++) push_data(32'h90 + 32'(i));
        send_word(SYNC);
        for (int i = 1; i <= 3; i++) send_word(32'h90 + 32'(i));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_locked", 32'(locked_o), 32'd0);
        chk("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("midrst_sync", 32'(sync_reset_o), 32'd0);
        chk("midrst_loss_cnt", 32'(lock_loss_cnt_o), 32'd0);
        @(posedge clk); #1;
        send_word(32'h95);
        send_word(32'h96);
        send_frame(SYNC, 32'hA0, 1'b0, 1'b0);
        send_frame(SYNC, 32'hA0, 1'b0, 1'b0);
        chk("postrst_2markers_locked", 32'(locked_o), 32'd0);
        send_frame(SYNC, 32'hA0, 1'b1, 1'b1);
        chk("postrst_locked", 32'(locked_o), 32'd1);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
